// File: rtl/calc_pkg.sv
// Shared definitions for the calculator instruction interface: word layout,
// sender FSM states and the instruction packing helper.
package calc_pkg;

    localparam int OP_W    = 2;
    localparam int OPND_W  = 8;
    localparam int INSTR_W = OP_W + 2 * OPND_W;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Instruction word layout: {op[17:16], a[15:8], b[7:0]}.
    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [OP_W-1:0]   op,
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b
    );
        return {op, a, b};
    endfunction

endpackage

// File: rtl/calc_instr_buf.sv
// Batch storage: DEPTH x INSTR_W register file, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module calc_instr_buf
    import calc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/calc_instr_sender.sv
// Transmit side of the calculator instruction load interface: collects one
// batch from the host, bursts it onto DIN, then holds off while it executes.
module calc_instr_sender
    import calc_pkg::*;
#(
    parameter int                 DEPTH       = 16,
    parameter int                 EXEC_CYCLES = 16,
    parameter logic [INSTR_W-1:0] PAD_WORD    = 18'h00000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [OPND_W-1:0]  in_a,
    input  logic [OPND_W-1:0]  in_b,
    input  logic               flush,
    output logic [INSTR_W-1:0] dout,
    output logic               dout_valid,
    output logic               calc_start,
    output logic               busy,
    output logic [7:0]         batch_count
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WC_W  = $clog2(EXEC_CYCLES) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]   send_idx_q, send_idx_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0]         batch_count_q, batch_count_d;

    logic               in_ready_s;
    logic               accept_s;
    logic [INSTR_W-1:0] rdata_s;

    assign in_ready_s = (state_q == FILL) && (fill_cnt_q < CNT_W'(DEPTH));
    assign accept_s   = in_valid && in_ready_s;

    calc_instr_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (accept_s),
        .waddr (fill_cnt_q[AW-1:0]),
        .wdata (pack_instr(in_op, in_a, in_b)),
        .raddr (send_idx_q[AW-1:0]),
        .rdata (rdata_s)
    );

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            fill_cnt_q    <= {CNT_W{1'b0}};
            send_idx_q    <= {CNT_W{1'b0}};
            n_q           <= {CNT_W{1'b0}};
            wait_cnt_q    <= {WC_W{1'b0}};
            batch_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            fill_cnt_q    <= fill_cnt_d;
            send_idx_q    <= send_idx_d;
            n_q           <= n_d;
            wait_cnt_q    <= wait_cnt_d;
            batch_count_q <= batch_count_d;
        end
    end

    // Next-state logic: fill, burst, then execution hold-off
    always_comb begin
        state_d       = state_q;
        fill_cnt_d    = fill_cnt_q;
        send_idx_d    = send_idx_q;
        n_d           = n_q;
        wait_cnt_d    = wait_cnt_q;
        batch_count_d = batch_count_q;
        case (state_q)
            FILL: begin
                fill_cnt_d = accept_s ? (fill_cnt_q + CNT_W'(1)) : fill_cnt_q;
                // fill_cnt_d != 0 covers both a prior partial batch and a word accepted with the flush
                if ((fill_cnt_d == CNT_W'(DEPTH)) || (flush && (fill_cnt_d != {CNT_W{1'b0}}))) begin
                    state_d    = SEND;
                    send_idx_d = {CNT_W{1'b0}};
                    n_d        = fill_cnt_d;
                end else begin
                    state_d    = FILL;
                end
            end
            SEND: begin
                send_idx_d = send_idx_q + CNT_W'(1);
                if (send_idx_q == CNT_W'(DEPTH - 1)) begin
                    state_d       = WAIT;
                    wait_cnt_d    = WC_W'(EXEC_CYCLES - 1);
                    batch_count_d = batch_count_q + 8'd1;
                end else begin
                    state_d       = SEND;
                end
            end
            WAIT: begin
                if (wait_cnt_q == {WC_W{1'b0}}) begin
                    state_d    = FILL;
                    fill_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = wait_cnt_q - WC_W'(1);
                end
            end
            default: begin
                state_d    = FILL;
                fill_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        dout       = {INSTR_W{1'b0}};
        dout_valid = 1'b0;
        calc_start = 1'b0;
        if (state_q == SEND) begin
            dout_valid = 1'b1;
            calc_start = (send_idx_q == {CNT_W{1'b0}});
            if (send_idx_q < n_q) begin
                dout = rdata_s;
            end else begin
                dout = PAD_WORD;
            end
        end else begin
            dout_valid = 1'b0;
        end
    end

    assign in_ready    = in_ready_s;
    assign busy        = (state_q != FILL);
    assign batch_count = batch_count_q;

endmodule

// File: tb/tb_calc_instr_sender.sv
// Directed bench for calc_instr_sender: full batch, flushes, backpressure
// and asynchronous reset in the middle of a burst.
module tb_calc_instr_sender;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        flush;
    logic [17:0] dout;
    logic        dout_valid;
    logic        calc_start;
    logic        busy;
    logic [7:0]  batch_count;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_w [16];

    calc_instr_sender dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .flush       (flush),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .calc_start  (calc_start),
        .busy        (busy),
        .batch_count (batch_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [17:0] w);
        in_valid = 1'b1;
        in_op    = w[17:16];
        in_a     = w[15:8];
        in_b     = w[7:0];
    endtask

    // Called in the cycle where word 0 should be on dout; checks the burst
    // (nreal real words then pads) and the 16 hold-off cycles that follow.
    task automatic check_burst(input int nreal, input logic [7:0] exp_batch);
        for (int k = 0; k < 16; k++) begin
            check_eq("burst_valid", 32'(dout_valid), 32'd1);
            check_eq("burst_word", 32'(dout), (k < nreal) ? 32'(exp_w[k]) : 32'd0);
            check_eq("burst_start", 32'(calc_start), (k == 0) ? 32'd1 : 32'd0);
            check_eq("burst_ready", 32'(in_ready), 32'd0);
            check_eq("burst_busy", 32'(busy), 32'd1);
            step();
        end
        for (int w = 0; w < 16; w++) begin
            check_eq("wait_busy", 32'(busy), 32'd1);
            check_eq("wait_valid", 32'(dout_valid), 32'd0);
            check_eq("wait_dout", 32'(dout), 32'd0);
            check_eq("wait_ready", 32'(in_ready), 32'd0);
            step();
        end
        check_eq("fill_ready", 32'(in_ready), 32'd1);
        check_eq("fill_busy", 32'(busy), 32'd0);
        check_eq("batch_count", 32'(batch_count), 32'(exp_batch));
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'd0;
        in_a     = 8'd0;
        in_b     = 8'd0;
        flush    = 1'b0;
        #1;
        step();
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_valid", 32'(dout_valid), 32'd0);
        check_eq("rst_start", 32'(calc_start), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_batch", 32'(batch_count), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Full batch, then backpressure with 3_FFFF held through SEND and WAIT
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = {2'(i % 4), 8'(i), 8'(2 * i)};
            check_eq("full_ready", 32'(in_ready), 32'd1);
            check_eq("full_idle", 32'(dout_valid), 32'd0);
            drive(exp_w[i]);
            step();
        end
        drive(18'h3_FFFF);
        check_burst(16, 8'd1);

        // First FILL edge takes the held word; flush on that same edge
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_w[0] = 18'h3_FFFF;
        check_burst(1, 8'd2);

        // Flush of a 3-word partial batch
        exp_w[0] = 18'h1_0203;
        exp_w[1] = 18'h2_0405;
        exp_w[2] = 18'h3_0607;
        for (int i = 0; i < 3; i++) begin
            drive(exp_w[i]);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check_burst(3, 8'd3);

        // Flush concurrent with the 5th transfer
        for (int i = 0; i < 5; i++) begin
            exp_w[i] = {2'(i % 4), 8'(8'h10 + i), 8'(8'hA0 + i)};
            drive(exp_w[i]);
            flush = (i == 4);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        check_burst(5, 8'd4);

        // Flush while empty is ignored
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("empty_valid", 32'(dout_valid), 32'd0);
            check_eq("empty_busy", 32'(busy), 32'd0);
            check_eq("empty_ready", 32'(in_ready), 32'd1);
            check_eq("empty_batch", 32'(batch_count), 32'd4);
            step();
        end

        // Reset in the middle of a burst at send_idx 7
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = {2'((i + 1) % 4), 8'(8'h40 + i), 8'(8'hC0 + i)};
            drive(exp_w[i]);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check_eq("mid_word7", 32'(dout), 32'(exp_w[7]));
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(dout_valid), 32'd0);
        check_eq("arst_dout", 32'(dout), 32'd0);
        check_eq("arst_ready", 32'(in_ready), 32'd1);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_batch", 32'(batch_count), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Next full batch carries only new data
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = {2'(3 - (i % 4)), 8'(8'h80 + i), 8'(8'h20 + i)};
            drive(exp_w[i]);
            step();
        end
        in_valid = 1'b0;
        check_burst(16, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
